// File: rtl/mem_responder.sv
// mem_responder: main-memory side of the cache interface with fixed-latency line refills and write-through word writes.
// Build option: define MEM_CWF_EN for critical-word-first read bursts that wrap within the line.
module mem_responder #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_busy,
  output logic              mem_data_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_last,
  output logic [1:0]        dbg_state
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(LATENCY - 1);
  localparam logic [OFF_W-1:0] BEAT_END = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_RBURST = 2'd2,
    S_WRITE  = 2'd3
  } state_t;

  // Handshake: a request is taken on any rising edge with mem_req=1 while
  // mem_busy=0 (IDLE only); mem_data_ready is a one-cycle strobe per beat or
  // acknowledge with no backpressure, and mem_last marks the final one.
  state_t              state;
  state_t              state_nxt;
  logic [LAT_W-1:0]    lat_cnt;
  logic [OFF_W-1:0]    beat_cnt;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [OFF_W-1:0]    beat_off;
  logic [ADDR_W-1:0]   beat_addr;
  logic [DATA_W-1:0]   store [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      lat_cnt  <= '0;
      beat_cnt <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (mem_req) begin
            rw_q     <= mem_rw;
            addr_q   <= mem_addr;
            wdata_q  <= mem_wdata;
            lat_cnt  <= '0;
            beat_cnt <= '0;
          end
        end
        S_WAIT:   lat_cnt  <= lat_cnt + 1'b1;
        S_RBURST: beat_cnt <= beat_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Store contents survive reset; a write caught by reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && state == S_WRITE) begin
      store[addr_q] <= wdata_q;
    end
  end

`ifdef MEM_CWF_EN
  assign beat_off = addr_q[OFF_W-1:0] + beat_cnt;
`else
  assign beat_off = beat_cnt;
`endif

  // The offset field wraps on its own, so beats never carry into the line address.
  assign beat_addr = {addr_q[ADDR_W-1:OFF_W], beat_off};

  always_comb begin
    state_nxt      = state;
    mem_busy       = 1'b0;
    mem_data_ready = 1'b0;
    mem_last       = 1'b0;
    mem_rdata      = '0;
    case (state)
      S_IDLE: begin
        if (mem_req) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        mem_busy = 1'b1;
        if (lat_cnt == LAT_END) state_nxt = rw_q ? S_WRITE : S_RBURST;
      end
      S_RBURST: begin
        mem_busy       = 1'b1;
        mem_data_ready = 1'b1;
        mem_rdata      = store[beat_addr];
        if (beat_cnt == BEAT_END) begin
          mem_last  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        mem_busy       = 1'b1;
        mem_data_ready = 1'b1;
        mem_last       = 1'b1;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder against an array/arithmetic memory model.
// Define MEM_CWF_EN for both bench and RTL to check the critical-word-first build.
module tb_mem_responder;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LW     = 4;
  localparam int LAT    = 3;
  localparam int MAXC   = 64;
  localparam int NONE   = -10;
`ifdef MEM_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic              mem_req   = 1'b0;
  logic              mem_rw    = 1'b0;
  logic [ADDR_W-1:0] mem_addr  = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic              mem_busy;
  logic              mem_data_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_last;
  logic [1:0]        dbg_state;

  mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_busy(mem_busy),
    .mem_data_ready(mem_data_ready), .mem_rdata(mem_rdata), .mem_last(mem_last),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- model and scoreboard state ----------------
  int                n_checks = 0;
  int                n_errors = 0;
  logic [DATA_W-1:0] model [2**ADDR_W];
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] known_lines [7];
  logic              tr_busy  [MAXC];
  logic              tr_ready [MAXC];
  logic              tr_last  [MAXC];
  logic [DATA_W-1:0] tr_rdata [MAXC];

  function automatic logic [ADDR_W-1:0] beat_addr_f(input logic [ADDR_W-1:0] a, input int i);
    int ai, base, off;
    ai   = int'(a);
    base = ai - (ai % LW);
    off  = CWF ? (((ai % LW) + i) % LW) : i;
    return ADDR_W'(base + off);
  endfunction

  // Expected control outputs k cycles after the accepting edge.
  function automatic void exp_ctrl(input bit rw, input int k, output bit b, output bit r, output bit l);
    int n;
    n = rw ? 1 : LW;
    b = (k >= 1) && (k <= LAT + n);
    r = (k > LAT) && (k <= LAT + n);
    l = (k == LAT + n);
  endfunction

  function automatic void load_exp(input logic [ADDR_W-1:0] a);
    exp_q.delete();
    for (int i = 0; i < LW; i++) exp_q.push_back(model[beat_addr_f(a, i)]);
  endfunction

  // ---------------- driver ----------------
  // Issues one request and records ncyc samples taken on falling edges after
  // the accepting edge. hold keeps mem_req high; pulse_k/reset_k inject
  // a stray write request or a reset at sample k.
  task automatic run_txn(input bit rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input int ncyc, input bit hold, input int pulse_k, input int reset_k);
    @(negedge clk);
    mem_req   = 1'b1;
    mem_rw    = rw;
    mem_addr  = a;
    mem_wdata = d;
    @(negedge clk);
    for (int k = 1; k <= ncyc; k++) begin
      if (!hold) begin
        mem_req   = 1'b0;
        mem_rw    = 1'($urandom);
        mem_addr  = ADDR_W'($urandom);
        mem_wdata = $urandom;
      end
      if (k == pulse_k) begin
        mem_req   = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = 10'h020;
        mem_wdata = 32'hDEAD_0020;
      end
      if (k == pulse_k + 1) mem_req = 1'b0;
      if (k == reset_k) reset = 1'b1;
      if (k == reset_k + 2) reset = 1'b0;
      tr_busy[k]  = mem_busy;
      tr_ready[k] = mem_data_ready;
      tr_last[k]  = mem_last;
      tr_rdata[k] = mem_rdata;
      if (k == ncyc) mem_req = 1'b0;
      @(negedge clk);
    end
    mem_req = 1'b0;
    reset   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks += 4;
      if (mem_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", c, mem_busy); end
      if (mem_data_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready cyc=%0d got=%b exp=0", c, mem_data_ready); end
      if (mem_last !== 1'b0) begin n_errors++; $display("FAIL reset_last cyc=%0d got=%b exp=0", c, mem_last); end
      if (mem_rdata !== '0) begin n_errors++; $display("FAIL reset_rdata cyc=%0d got=%h exp=0", c, mem_rdata); end
    end
  endtask

  task automatic test_write_through();
    logic [ADDR_W-1:0] wa[$];
    logic [DATA_W-1:0] wd[$];
    bit eb, er, el;
    wa = '{10'h010, 10'h011, 10'h012, 10'h013};
    wd = '{32'hAAAA_0010, 32'h11, 32'h12, 32'h13};
    known_lines[0] = 10'h010;
    known_lines[1] = 10'h020;
    known_lines[2] = 10'h030;
    known_lines[3] = 10'h3FC;
    for (int i = 4; i < 7; i++) known_lines[i] = ADDR_W'($urandom_range(0, 2**ADDR_W/LW - 1) * LW);
    for (int i = 1; i < 7; i++)
      for (int j = 0; j < LW; j++) begin
        wa.push_back(known_lines[i] + ADDR_W'(j));
        wd.push_back($urandom);
      end
    for (int w = 0; w < wa.size(); w++) begin
      run_txn(1'b1, wa[w], wd[w], LAT + 2, 1'b0, NONE, NONE);
      for (int k = 1; k <= LAT + 2; k++) begin
        exp_ctrl(1'b1, k, eb, er, el);
        n_checks += 3;
        if (tr_busy[k] !== eb) begin n_errors++; $display("FAIL wr_busy a=%h k=%0d got=%b exp=%b", wa[w], k, tr_busy[k], eb); end
        if (tr_ready[k] !== er) begin n_errors++; $display("FAIL wr_ack a=%h k=%0d got=%b exp=%b", wa[w], k, tr_ready[k], er); end
        if (tr_last[k] !== el) begin n_errors++; $display("FAIL wr_last a=%h k=%0d got=%b exp=%b", wa[w], k, tr_last[k], el); end
      end
      model[wa[w]] = wd[w];
    end
  endtask

  task automatic test_read();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] e;
    bit eb, er, el;
    for (int t = 0; t < 8; t++) begin
      if (t == 0) begin
        a = 10'h012;
        if (CWF) exp_q = '{32'h12, 32'h13, 32'hAAAA_0010, 32'h11};
        else     exp_q = '{32'hAAAA_0010, 32'h11, 32'h12, 32'h13};
      end else begin
        a = known_lines[$urandom_range(0, 6)] + ADDR_W'($urandom_range(0, LW - 1));
        load_exp(a);
      end
      run_txn(1'b0, a, '0, LAT + LW + 1, 1'b0, NONE, NONE);
      for (int k = 1; k <= LAT + LW + 1; k++) begin
        exp_ctrl(1'b0, k, eb, er, el);
        n_checks += 3;
        if (tr_busy[k] !== eb) begin n_errors++; $display("FAIL rd_busy a=%h k=%0d got=%b exp=%b", a, k, tr_busy[k], eb); end
        if (tr_ready[k] !== er) begin n_errors++; $display("FAIL rd_ready a=%h k=%0d got=%b exp=%b", a, k, tr_ready[k], er); end
        if (tr_last[k] !== el) begin n_errors++; $display("FAIL rd_last a=%h k=%0d got=%b exp=%b", a, k, tr_last[k], el); end
        if (tr_ready[k] === 1'b1) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++; $display("FAIL rd_extra_beat a=%h k=%0d got=%h exp=none", a, k, tr_rdata[k]);
          end else begin
            e = exp_q.pop_front();
            if (tr_rdata[k] !== e) begin n_errors++; $display("FAIL rd_data a=%h k=%0d got=%h exp=%h", a, k, tr_rdata[k], e); end
          end
        end
      end
      n_checks++;
      if (exp_q.size() != 0) begin n_errors++; $display("FAIL rd_missing_beats a=%h got=%0d exp=0 left", a, exp_q.size()); end
    end
  endtask

  task automatic test_ignore_during_burst();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] e;
    bit eb, er, el;
    for (int r = 0; r < 2; r++) begin
      a = (r == 0) ? 10'h021 : 10'h020;
      load_exp(a);
      run_txn(1'b0, a, '0, LAT + LW + 2, 1'b0, (r == 0) ? LAT + 2 : NONE, NONE);
      for (int k = 1; k <= LAT + LW + 2; k++) begin
        exp_ctrl(1'b0, k, eb, er, el);
        n_checks += 3;
        if (tr_busy[k] !== eb) begin n_errors++; $display("FAIL ign_busy r=%0d k=%0d got=%b exp=%b", r, k, tr_busy[k], eb); end
        if (tr_ready[k] !== er) begin n_errors++; $display("FAIL ign_ready r=%0d k=%0d got=%b exp=%b", r, k, tr_ready[k], er); end
        if (tr_last[k] !== el) begin n_errors++; $display("FAIL ign_last r=%0d k=%0d got=%b exp=%b", r, k, tr_last[k], el); end
        if (tr_ready[k] === 1'b1 && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_checks++;
          if (tr_rdata[k] !== e) begin n_errors++; $display("FAIL ign_data r=%0d k=%0d got=%h exp=%h", r, k, tr_rdata[k], e); end
        end
      end
      n_checks++;
      if (exp_q.size() != 0) begin n_errors++; $display("FAIL ign_beats r=%0d got=%0d exp=0 left", r, exp_q.size()); end
    end
  endtask

  task automatic test_reset_abort();
    bit                rws [4];
    logic [ADDR_W-1:0] as  [4];
    int                rks [4];
    int                ncs [4];
    int                nb, exp_nb;
    logic [DATA_W-1:0] e;
    bit eb, er, el;
    rws = '{1'b0, 1'b1, 1'b0, 1'b0};
    as  = '{10'h011, 10'h030, 10'h030, 10'h011};
    rks = '{LAT + 2, 1, NONE, NONE};
    ncs = '{LAT + 6, LAT + 4, LAT + LW + 1, LAT + LW + 1};
    for (int r = 0; r < 4; r++) begin
      load_exp(as[r]);
      run_txn(rws[r], as[r], 32'hBADC_0DE0, ncs[r], 1'b0, NONE, rks[r]);
      nb = 0;
      exp_nb = rws[r] ? 0 : ((rks[r] == NONE) ? LW : rks[r] - LAT);
      for (int k = 1; k <= ncs[r]; k++) begin
        if (rks[r] != NONE && k > rks[r]) begin eb = 0; er = 0; el = 0; end
        else exp_ctrl(rws[r], k, eb, er, el);
        n_checks += 3;
        if (tr_busy[k] !== eb) begin n_errors++; $display("FAIL abort_busy r=%0d k=%0d got=%b exp=%b", r, k, tr_busy[k], eb); end
        if (tr_ready[k] !== er) begin n_errors++; $display("FAIL abort_ready r=%0d k=%0d got=%b exp=%b", r, k, tr_ready[k], er); end
        if (tr_last[k] !== el) begin n_errors++; $display("FAIL abort_last r=%0d k=%0d got=%b exp=%b", r, k, tr_last[k], el); end
        if (!rws[r] && tr_ready[k] === 1'b1) begin
          nb++;
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (tr_rdata[k] !== e) begin n_errors++; $display("FAIL abort_data r=%0d k=%0d got=%h exp=%h", r, k, tr_rdata[k], e); end
          end
        end
        if (!rws[r] && rks[r] != NONE && k > rks[r]) begin
          n_checks++;
          if (tr_rdata[k] !== '0) begin n_errors++; $display("FAIL abort_rdata_zero r=%0d k=%0d got=%h exp=0", r, k, tr_rdata[k]); end
        end
      end
      n_checks++;
      if (nb != exp_nb) begin n_errors++; $display("FAIL abort_beat_count r=%0d got=%0d exp=%0d", r, nb, exp_nb); end
    end
  endtask

  task automatic test_back_to_back();
    int                span, kk;
    logic [DATA_W-1:0] e;
    bit eb, er, el;
    span = LAT + LW + 1;
    load_exp(10'h3FC);
    for (int i = 0; i < LW; i++) exp_q.push_back(model[10'h3FC + ADDR_W'(i)]);
    run_txn(1'b0, 10'h3FC, '0, 2 * span, 1'b1, NONE, NONE);
    for (int k = 1; k <= 2 * span; k++) begin
      kk = (k <= span) ? k : k - span;
      exp_ctrl(1'b0, kk, eb, er, el);
      n_checks += 3;
      if (tr_busy[k] !== eb) begin n_errors++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, tr_busy[k], eb); end
      if (tr_ready[k] !== er) begin n_errors++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, tr_ready[k], er); end
      if (tr_last[k] !== el) begin n_errors++; $display("FAIL b2b_last k=%0d got=%b exp=%b", k, tr_last[k], el); end
      if (tr_ready[k] === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (tr_rdata[k] !== e) begin n_errors++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, tr_rdata[k], e); end
      end
    end
    n_checks += 2;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL b2b_beats got=%0d exp=0 left", exp_q.size()); end
    if (mem_busy !== 1'b0) begin n_errors++; $display("FAIL b2b_no_third got=%b exp=0", mem_busy); end
  endtask

  initial begin
    test_reset();
    test_write_through();
    test_read();
    test_ignore_during_burst();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Main-memory side of the cache/memory interface; the responder to the cache controller FSM.
- Services two request types:
  - Line refills on a read miss: multi-beat read burst; the final beat drives the controller's memory-data-ready input.
  - Write-through word writes: single write followed by a one-cycle acknowledge.
- Contains the backing word store and models a fixed access latency.

Parameters:
- ADDR_W, 10, word address width; store depth is 2**ADDR_W words.
- DATA_W, 32, data word width.
- LINE_WORDS, 4, words per cache line. Power of two, >= 2.
- LATENCY, 3, wait cycles between request acceptance and the first data or acknowledge. Must be >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_req  in  1  request valid. Sampled only in IDLE.
- mem_rw  in  1  1 = write-through word write; 0 = line read.
- mem_addr  in  ADDR_W  word address.
- mem_wdata  in  DATA_W  write data.
- mem_busy  out  1  high in every state except IDLE.
- mem_data_ready  out  1  one-cycle strobe per read beat, or the write acknowledge.
- mem_rdata  out  DATA_W  read beat data. Valid only while mem_data_ready=1 and rw=0.
- mem_last  out  1  high with the final read beat and with the write acknowledge.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high on reset.
- Reset:
  - State goes to IDLE; counters are cleared.
  - mem_busy, mem_data_ready and mem_last go to 0; mem_rdata goes to 0.
  - The store contents are NOT reset.
  - Reset asserted mid-burst or mid-wait aborts the transaction. No further beats are issued, and a pending write is not performed.
- States: IDLE, WAIT, RBURST, WRITE.
- IDLE:
  - If mem_req=1 at a rising edge, latch rw, addr and wdata, then go to WAIT with lat_cnt=0.
  - Read base address = addr with the low log2(LINE_WORDS) bits cleared.
- WAIT:
  - lat_cnt increments every cycle.
  - When lat_cnt = LATENCY-1, go to RBURST (rw=0) or WRITE (rw=1).
  - First response cycle is therefore LATENCY+1 cycles after the accepting edge.
- RBURST:
  - Lasts LINE_WORDS consecutive cycles, beat index i = 0..LINE_WORDS-1.
  - Each cycle: mem_data_ready=1, mem_rdata = store[base+i].
  - mem_last=1 on i = LINE_WORDS-1; the next state is IDLE.
  - Beat addresses never leave the aligned line; there is no carry into the upper address bits.
- WRITE:
  - Lasts one cycle.
  - store[latched addr] <= latched wdata; mem_data_ready=1, mem_last=1. Next state is IDLE.
- Request handling:
  - mem_req is ignored while mem_busy=1; there is no queueing.
  - The requester deasserts mem_req on the cycle it observes mem_last. If mem_req is still high in IDLE, it is accepted as a new request.
  - Inputs are latched at acceptance. Changes to mem_addr, mem_wdata or mem_rw while busy have no effect.
- Read data timing:
  - The store is read combinationally from the registered address, or from a registered read one cycle early. Either way mem_rdata must align with mem_data_ready in the same cycle.
- Back-to-back transactions: minimum gap is one IDLE cycle between the last beat or acknowledge and the next accepting edge.

Optional Feature:
- MEM_CWF_EN (critical word first):
  - Defined: read bursts start at the requested word and wrap within the line. Beat i address = base + ((addr_offset + i) mod LINE_WORDS). mem_last still marks the LINE_WORDS-th beat.
  - Undefined: bursts always start at offset 0, as above.
  - Write behaviour is identical in both builds.

Test Plan:
- Reset, then idle with mem_req=0 for 5 cycles -> mem_busy=0, mem_data_ready=0, mem_last=0, mem_rdata=0 every cycle.
- Write 0xAAAA0010 to 0x010 (req accepted at edge T0), then writes 0x11, 0x12, 0x13 to 0x011..0x013 -> each acknowledge is a single cycle of mem_data_ready=mem_last=1 at T0+4; mem_busy=1 for T1..T4.
- Read at 0x012 after the writes above:
  - Without MEM_CWF_EN -> beats at T4..T7 carry 0xAAAA0010, 0x11, 0x12, 0x13; mem_last only at T7.
  - With MEM_CWF_EN -> beats carry 0x12, 0x13, 0xAAAA0010, 0x11.
- Pulse mem_req with mem_rw=1, addr 0x020 during a read burst -> ignored; store[0x020] unchanged; the burst completes with exactly 4 beats.
- Assert reset at the 2nd beat of a read burst, and separately during WAIT of a write to 0x030 -> outputs are 0 the next cycle; no further beats; store[0x030] keeps its old value; the next read returns the pre-reset contents.
- Hold mem_req=1 with a read at 0x3FC -> beats from 0x3FC..0x3FF with no wrap to 0x000; a new request is accepted on the edge after the IDLE cycle that follows mem_last.
